// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/add ops, bit-serial shifts, optional shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build the WIDTH-step multiplier; otherwise opcode 01001 reports err.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic             ipsel,
    input  logic [4:0]       opsel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             err
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_XOR = 5'b00100;
    localparam logic [4:0] OP_NOT = 5'b00101;
    localparam logic [4:0] OP_SLA = 5'b00110;
    localparam logic [4:0] OP_SRA = 5'b00111;
    localparam logic [4:0] OP_SRL = 5'b01000;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [4:0] OP_MUL = 5'b01001;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] work;
    logic [SHW:0]     cnt;

    logic [WIDTH-1:0] op2;
    logic [SHW-1:0]   shamt;
    logic             accept;
    logic             last_step;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] quick_res;
    logic             quick_carry;
    logic             quick_err;
    logic             quick_busy;

    logic [WIDTH-1:0] step_res;
    logic             step_carry;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   hsum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
`endif

    assign op2       = ipsel ? imm : b;
    assign shamt     = op2[SHW-1:0];
    assign accept    = in_valid & in_ready;
    assign last_step = (cnt == (SHW+1)'(1));

    // Decode of the operation being presented; single-cycle results come straight from here.
    always_comb begin
        sum         = {1'b0, a} + {1'b0, op2};
        quick_res   = '0;
        quick_carry = 1'b0;
        quick_err   = 1'b0;
        quick_busy  = 1'b0;
        case (opsel)
            OP_ADD: begin
                quick_res   = sum[WIDTH-1:0];
                quick_carry = sum[WIDTH];
            end
            OP_SUB: begin
                sum         = {1'b0, a} + {1'b0, ~op2} + (WIDTH+1)'(1);
                quick_res   = sum[WIDTH-1:0];
                quick_carry = sum[WIDTH];
            end
            OP_AND: quick_res = a & op2;
            OP_OR:  quick_res = a | op2;
            OP_XOR: quick_res = a ^ op2;
            OP_NOT: quick_res = ~op2;
            OP_SLA, OP_SRA, OP_SRL: begin
                quick_res  = a;
                quick_busy = (shamt != '0);
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: quick_busy = 1'b1;
`endif
            default: quick_err = 1'b1;
        endcase
    end

    // One-bit shift step on the working register.
    always_comb begin
        step_res   = work;
        step_carry = 1'b0;
        case (op_q)
            OP_SLA: begin
                step_res   = {work[WIDTH-2:0], 1'b0};
                step_carry = work[WIDTH-1];
            end
            OP_SRA: begin
                step_res   = {work[WIDTH-1], work[WIDTH-1:1]};
                step_carry = work[0];
            end
            OP_SRL: begin
                step_res   = {1'b0, work[WIDTH-1:1]};
                step_carry = work[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // Shift-add step: {hi, work} holds the partial product with the multiplier in its low half.
    always_comb begin
        hsum   = {1'b0, hi} + {1'b0, (work[0] ? mcand : '0)};
        mul_hi = hsum[WIDTH:1];
        mul_lo = {hsum[0], work[WIDTH-1:1]};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    if (accept) state_nxt = quick_busy ? BUSY : DONE;
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output registers are written only on the transition into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            work   <= '0;
            cnt    <= '0;
            result <= '0;
            carry  <= 1'b0;
            err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            hi     <= '0;
            mcand  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= opsel;
                        work <= a;
                        cnt  <= {1'b0, shamt};
                        if (!quick_busy) begin
                            result <= quick_res;
                            carry  <= quick_carry;
                            err    <= quick_err;
                        end
`ifdef ALU_SEQ_MUL_EN
                        if (opsel == OP_MUL) begin
                            work  <= op2;
                            mcand <= a;
                            hi    <= '0;
                            cnt   <= (SHW+1)'(WIDTH);
                        end
`endif
                    end
                end
                BUSY: begin
                    cnt <= cnt - (SHW+1)'(1);
`ifdef ALU_SEQ_MUL_EN
                    if (op_q == OP_MUL) begin
                        hi   <= mul_hi;
                        work <= mul_lo;
                        if (last_step) begin
                            result <= mul_lo;
                            carry  <= |mul_hi;
                            err    <= 1'b0;
                        end
                    end else
`endif
                    begin
                        work <= step_res;
                        if (last_step) begin
                            result <= step_res;
                            carry  <= step_carry;
                            err    <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model predictions, negedge monitor pops and compares.
// Honours ALU_SEQ_MUL_EN the same way as the design.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] imm;
    logic         ipsel;
    logic [4:0]   opsel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         err;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .imm      (imm),
        .ipsel    (ipsel),
        .opsel    (opsel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .carry    (carry),
        .err      (err)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         e;
        int           lat;
        int           base;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    bit   holding = 0;
    bit   bp_hold = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Random consumer backpressure, forced low during the hold test.
    always @(posedge clk) begin
        #1;
        out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference model from the opcode table, using wide plain arithmetic.
    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t         r;
        int           sh;
        logic [63:0]  p;
        r.res = '0; r.c = 1'b0; r.e = 1'b0; r.lat = 1; r.base = 0;
        sh = int'(bv % W);
        case (op)
            5'd0: begin p = 64'(av) + 64'(bv); r.res = p[W-1:0]; r.c = p[W]; end
            5'd1: begin r.res = av - bv; r.c = (av >= bv); end
            5'd2: r.res = av & bv;
            5'd3: r.res = av | bv;
            5'd4: r.res = av ^ bv;
            5'd5: r.res = ~bv;
            5'd6: begin r.res = av << sh; r.c = (sh == 0) ? 1'b0 : av[W-sh]; r.lat = 1 + sh; end
            5'd7: begin r.res = W'($signed(av) >>> sh); r.c = (sh == 0) ? 1'b0 : av[sh-1]; r.lat = 1 + sh; end
            5'd8: begin r.res = av >> sh; r.c = (sh == 0) ? 1'b0 : av[sh-1]; r.lat = 1 + sh; end
`ifdef ALU_SEQ_MUL_EN
            5'd9: begin p = 64'(av) * 64'(bv); r.res = p[W-1:0]; r.c = (p[63:W] != 0); r.lat = W + 1; end
`endif
            default: r.e = 1'b1;
        endcase
        return r;
    endfunction

    task automatic applyStimulus(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [W-1:0] iv, input logic sel);
        exp_t e;
        int   waited = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1; opsel = op; a = av; b = bv; imm = iv; ipsel = sel;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 300) begin
                checkOutput("accept_timeout", 64'(waited), 64'd0);
                in_valid = 1'b0;
                return;
            end
        end
        e = model(op, av, sel ? iv : bv);
        e.base = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; imm = $urandom; opsel = 5'($urandom); ipsel = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) holding = 0;
        else if (out_valid) begin
            if (!holding) begin
                if (q.size() == 0) checkOutput("unexpected_out_valid", 64'd1, 64'd0);
                else begin
                    cur = q.pop_front();
                    checkOutput("result", 64'(result), 64'(cur.res));
                    checkOutput("carry", 64'(carry), 64'(cur.c));
                    checkOutput("err", 64'(err), 64'(cur.e));
                    checkOutput("latency", 64'(cyc - cur.base), 64'(cur.lat));
                end
            end else begin
                checkOutput("held_outputs", 64'({result, carry, err}), 64'({cur.res, cur.c, cur.e}));
            end
            holding = !out_ready;
        end else holding = 0;
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; imm = '0; ipsel = 1'b0; opsel = '0;
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_outputs", 64'({result, carry, err}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus(5'd0, 32'd3, 32'd7, 32'd0, 1'b0);
        applyStimulus(5'd1, 32'd3, 32'd7, 32'd0, 1'b0);
        applyStimulus(5'd1, 32'd7, 32'd99, 32'd3, 1'b1);
        applyStimulus(5'd6, 32'd3, 32'd5, 32'd0, 1'b0);
        applyStimulus(5'd7, 32'h8000_0000, 32'd4, 32'd0, 1'b0);
        applyStimulus(5'd9, 32'd3, 32'd7, 32'd0, 1'b0);
        applyStimulus(5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        applyStimulus(5'd5, 32'd0, 32'h0F0F_00FF, 32'd0, 1'b0);
        applyStimulus(5'd8, 32'hF000_000F, 32'hFFFF_FFE3, 32'd0, 1'b0);
        applyStimulus(5'd6, 32'h1234_5678, 32'h0000_0020, 32'd0, 1'b0);
        applyStimulus(5'd7, 32'h8000_0001, 32'd31, 32'd0, 1'b0);
        applyStimulus(5'd31, 32'd5, 32'd5, 32'd0, 1'b0);
        drain();

        // Backpressure: result held, new requests ignored while DONE.
        @(negedge clk);
        bp_hold = 1;
        applyStimulus(5'd0, 32'd5, 32'd6, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1; opsel = 5'd0; a = 32'd100; b = 32'd1; ipsel = 1'b0;
            @(negedge clk);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        bp_hold = 0;
        applyStimulus(5'd0, 32'd100, 32'd1, 32'd0, 1'b0);
        drain();

        for (int i = 0; i < 80; i++) begin
            applyStimulus(5'($urandom_range(0, 15)), $urandom, $urandom, $urandom, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

        // Asynchronous reset while a long operation is in flight.
`ifdef ALU_SEQ_MUL_EN
        applyStimulus(5'd9, 32'hDEAD_BEEF, 32'h1234_5677, 32'd0, 1'b0);
`else
        applyStimulus(5'd8, 32'hDEAD_BEEF, 32'd31, 32'd0, 1'b0);
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort_outputs", 64'({result, carry, err}), 64'd0);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(5'd0, 32'd1, 32'd1, 32'd0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
